// File: rtl/imem_responder.sv
// Instruction-memory responder for the fetch path: a word array with a backdoor preload
// port, a valid/ready fetch handshake and a programmable response latency.

module imem_responder #(
   parameter int DEPTH_WORDS = 64,
   parameter int LATENCY     = 1,
   parameter int LD_AW       = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [31:0]      PC_In,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_err,
   output logic [31:0]      InstMem_Out,
   output logic [5:0]       addr,
   output logic [4:0]       rs,
   output logic [4:0]       rt,
   output logic [4:0]       rd,
   output logic [4:0]       shamt,
   output logic [5:0]       funct,
   output logic [15:0]      imm,
   output logic [25:0]      JTA,
   input  logic             ld_en,
   input  logic [LD_AW-1:0] ld_addr,
   input  logic [31:0]      ld_data,
   output logic             ld_drop
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   logic [31:0] mem_r [DEPTH_WORDS];

   state_t      state_r;
   logic [2:0]  cnt_r;
   logic [31:0] pc_r;
   logic        ready_r;
   logic        rsp_valid_r;
   logic        rsp_err_r;
   logic [31:0] inst_r;
   logic        ld_drop_r;

   logic        ld_ok_s;
   logic        err_s;
   logic [31:0] rd_word_s;

   // Misaligned or beyond the array: never aliased onto a real word.
   function automatic logic fetch_err(input logic [31:0] pc);
      return (pc[1:0] != 2'b00) || ({2'b00, pc[31:2]} >= 32'(DEPTH_WORDS));
   endfunction

   // Preload qualification and the word read for the latched fetch address.
   always_comb begin
      ld_ok_s   = 1'b0;
      err_s     = 1'b0;
      rd_word_s = 32'h0000_0000;
      ld_ok_s   = ld_en && !reset && (state_r == ST_IDLE) && !req_valid &&
                  (32'(ld_addr) < 32'(DEPTH_WORDS));
      err_s     = fetch_err(pc_r);
      if (err_s) begin
         rd_word_s = 32'h0000_0000;
      end else begin
         rd_word_s = mem_r[pc_r[LD_AW+1:2]];
      end
   end

   // Backdoor preload; the array survives reset.
   always_ff @(posedge clk) begin
      if (ld_ok_s) begin
         mem_r[ld_addr] <= ld_data;
      end
   end

   // Fetch FSM. Every fetch passes through WAIT so the word is captured exactly
   // LATENCY edges after acceptance, including the single-cycle case.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         cnt_r       <= 3'd0;
         pc_r        <= 32'h0000_0000;
         ready_r     <= 1'b1;
         rsp_valid_r <= 1'b0;
         rsp_err_r   <= 1'b0;
         inst_r      <= 32'h0000_0000;
         ld_drop_r   <= 1'b0;
      end else begin
         ld_drop_r <= ld_en && !ld_ok_s;
         case (state_r)
            ST_IDLE: begin
               if (req_valid) begin
                  pc_r    <= PC_In;
                  cnt_r   <= 3'(LATENCY - 1);
                  ready_r <= 1'b0;
                  state_r <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (cnt_r == 3'd0) begin
                  inst_r      <= rd_word_s;
                  rsp_err_r   <= err_s;
                  rsp_valid_r <= 1'b1;
                  state_r     <= ST_RESP;
               end else begin
                  cnt_r <= cnt_r - 3'd1;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid_r <= 1'b0;
                  ready_r     <= 1'b1;
                  state_r     <= ST_IDLE;
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               ready_r     <= 1'b1;
               rsp_valid_r <= 1'b0;
            end
         endcase
      end
   end

   // Ready is masked while reset is held so nothing is offered during reset.
   assign req_ready   = ready_r && !reset;
   assign rsp_valid   = rsp_valid_r;
   assign rsp_err     = rsp_err_r;
   assign ld_drop     = ld_drop_r;
   assign InstMem_Out = inst_r;
   assign addr        = inst_r[31:26];
   assign rs          = inst_r[25:21];
   assign rt          = inst_r[20:16];
   assign rd          = inst_r[15:11];
   assign shamt       = inst_r[10:6];
   assign funct       = inst_r[5:0];
   assign imm         = inst_r[15:0];
   assign JTA         = inst_r[25:0];

endmodule
